// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, x/y scan counters, registered
// sync/blanking aligned with x/y, line/frame strobes and a frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CLK_DIV  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       pixel_stb,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Range bounds are 11 bits so an end bound of exactly 1024 does not wrap.
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div_q, div_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       display_on_q, display_on_d;
    logic       pixel_stb_q, pixel_stb_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       tick_s;
    logic       h_wrap_s;
    logic       v_wrap_s;

    // Next-state: divider, scan counters, strobes and timing decoded from next x/y.
    always_comb begin
        tick_s        = en && (div_q == DIV_LAST);
        h_wrap_s      = (x_q == H_LAST);
        v_wrap_s      = (y_q == V_LAST);
        div_d         = div_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_count_d = frame_count_q;

        if (tick_s) begin
            div_d = 4'd0;
        end else if (en) begin
            div_d = div_q + 4'd1;
        end else begin
            div_d = div_q;
        end

        if (tick_s) begin
            if (h_wrap_s) begin
                x_d = 10'd0;
                if (v_wrap_s) begin
                    y_d           = 10'd0;
                    frame_count_d = frame_count_q + 8'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end else begin
            x_d = x_q;
        end

        pixel_stb_d   = tick_s;
        line_start_d  = tick_s && h_wrap_s;
        frame_start_d = tick_s && h_wrap_s && v_wrap_s;

        // Decoding from x_d/y_d keeps the registered sync outputs in step with x/y.
        hsync_d      = (({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d      = (({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END)) ? SYNC_POL : ~SYNC_POL;
        display_on_d = ({1'b0, x_d} < H_ACT) && ({1'b0, y_d} < V_ACT);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q         <= 4'd0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            frame_count_q <= 8'd0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            display_on_q  <= 1'b1;
            pixel_stb_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_count_q <= frame_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            pixel_stb_q   <= pixel_stb_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign pixel_stb   = pixel_stb_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three generator configurations share clk/rst_n/en; a driver
// pushes model-predicted outputs, a monitor pops and compares them each cycle.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ps;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic en;

    logic [9:0] x_s  [3];
    logic [9:0] y_s  [3];
    logic       hs_s [3];
    logic       vs_s [3];
    logic       de_s [3];
    logic       ps_s [3];
    logic       ls_s [3];
    logic       fs_s [3];
    logic [7:0] fc_s [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int total = 0;
    int bad   = 0;
    int n     = 0;

    // Instance 0: default 640x480, CLK_DIV=1
    vga_timing_gen u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .x(x_s[0]), .y(y_s[0]), .hsync(hs_s[0]), .vsync(vs_s[0]),
        .display_on(de_s[0]), .pixel_stb(ps_s[0]), .line_start(ls_s[0]),
        .frame_start(fs_s[0]), .frame_count(fc_s[0])
    );

    // Instance 1: default horizontal, short vertical, CLK_DIV=2, active-high sync
    vga_timing_gen #(
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1), .CLK_DIV(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .x(x_s[1]), .y(y_s[1]), .hsync(hs_s[1]), .vsync(vs_s[1]),
        .display_on(de_s[1]), .pixel_stb(ps_s[1]), .line_start(ls_s[1]),
        .frame_start(fs_s[1]), .frame_count(fc_s[1])
    );

    // Instance 2: tiny raster, 35 clks per frame
    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(1)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .x(x_s[2]), .y(y_s[2]), .hsync(hs_s[2]), .vsync(vs_s[2]),
        .display_on(de_s[2]), .pixel_stb(ps_s[2]), .line_start(ls_s[2]),
        .frame_start(fs_s[2]), .frame_count(fc_s[2])
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Reference: outputs follow from the number of enabled clocks since reset.
    function automatic exp_t model(input int cnt, input bit adv,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit pol, input int div);
        exp_t e;
        int ht, vt, ticks, idx, px, py;
        ht    = ha + hf + hsw + hb;
        vt    = va + vf + vsw + vb;
        ticks = cnt / div;
        idx   = ticks % (ht * vt);
        px    = idx % ht;
        py    = idx / ht;
        e.x   = 10'(px);
        e.y   = 10'(py);
        e.fc  = 8'((ticks / (ht * vt)) % 256);
        e.hs  = ((px >= ha + hf) && (px < ha + hf + hsw)) ? pol : ~pol;
        e.vs  = ((py >= va + vf) && (py < va + vf + vsw)) ? pol : ~pol;
        e.de  = (px < ha) && (py < va);
        e.ps  = adv && (cnt > 0) && (cnt % div == 0);
        e.ls  = e.ps && (px == 0);
        e.fs  = e.ls && (py == 0);
        return e;
    endfunction

    function automatic exp_t actual(input int i);
        exp_t a;
        a.x  = x_s[i];
        a.y  = y_s[i];
        a.hs = hs_s[i];
        a.vs = vs_s[i];
        a.de = de_s[i];
        a.ps = ps_s[i];
        a.ls = ls_s[i];
        a.fs = fs_s[i];
        a.fc = fc_s[i];
        return a;
    endfunction

    task automatic check(input int i, input exp_t e);
        exp_t a;
        a = actual(i);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL dut%0d t=%0t got x=%0d y=%0d hs=%b vs=%b de=%b ps=%b ls=%b fs=%b fc=%0d want x=%0d y=%0d hs=%b vs=%b de=%b ps=%b ls=%b fs=%b fc=%0d",
                     i, $time, a.x, a.y, a.hs, a.vs, a.de, a.ps, a.ls, a.fs, a.fc,
                     e.x, e.y, e.hs, e.vs, e.de, e.ps, e.ls, e.fs, e.fc);
        end
    endtask

    // Drive one clock's inputs and queue what each instance must show after it.
    task automatic step(input bit r, input bit e);
        @(negedge clk);
        rst_n = r;
        en    = e;
        if (!r) n = 0;
        else if (e) n++;
        q0.push_back(model(n, r && e, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1));
        q1.push_back(model(n, r && e, 640, 16, 96, 48, 6, 1, 2, 1, 1'b1, 2));
        q2.push_back(model(n, r && e, 4, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1));
    endtask

    // Monitor: compares each queued expectation just after the edge it describes.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (q0.size() > 0) check(0, q0.pop_front());
            if (q1.size() > 0) check(1, q1.pop_front());
            if (q2.size() > 0) check(2, q2.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) step(1'b0, 1'b1);
        repeat (300) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        repeat (100) step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        repeat (2000) step(1'b1, 1'b1);
        for (int k = 0; k < 38000; k++) begin
            step(1'b1, $urandom_range(0, 9) != 0);
        end
        repeat (2) @(posedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
